// File: rtl/cpu_pkg.sv
// Shared CPU types: word/register aliases, load access types and the
// writeback-stage state encoding, plus the load misalignment predicate.
package cpu_pkg;

   localparam int WORD_W    = 32;
   localparam int REGADDR_W = 5;
   localparam int REG_NUM   = 2 ** REGADDR_W;

   typedef logic [WORD_W-1:0]    word_t;
   typedef logic [REGADDR_W-1:0] regaddr_t;
   typedef logic                 bit_t;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LBU = 3'd1,
      LH  = 3'd2,
      LHU = 3'd3,
      LW  = 3'd4
   } load_type_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wb_state_t;

   // Halfwords need an even offset, words need offset 0; bytes never fault.
   function automatic logic is_misaligned(input load_type_t t, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (t)
         LH, LHU: mis = off[0];
         LW:      mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load aligner: selects the addressed byte/halfword/word from a
// word-aligned bus beat and sign- or zero-extends it to DATA_W.
module load_align
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        offset,
   input  load_type_t        load_type,
   output logic [DATA_W-1:0] ext
);

   function automatic logic [DATA_W-1:0] sext_byte(input logic signed [7:0] v);
      return {{(DATA_W-8){v[7]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] zext_byte(input logic [7:0] v);
      return {{(DATA_W-8){1'b0}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] sext_half(input logic signed [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] zext_half(input logic [15:0] v);
      return {{(DATA_W-16){1'b0}}, v};
   endfunction

   logic signed [7:0]  byte_sel;
   logic signed [15:0] half_sel;

   // Halfword select uses only off[1]; off[0] is deliberately ignored.
   always_comb begin
      byte_sel = data[{offset, 3'b000} +: 8];
      half_sel = data[{offset[1], 4'b0000} +: 16];
      case (load_type)
         LB:      ext = sext_byte(byte_sel);
         LBU:     ext = zext_byte(byte_sel);
         LH:      ext = sext_half(half_sel);
         LHU:     ext = zext_half(half_sel);
         default: ext = data;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: waits on the data-bus ack for loads, aligns load data and
// drives a registered GPR write port. Optional macro: WB_MISALIGN_EXC_EN.
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_valid,
   input  logic                 mem_we,
   input  logic [REGADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0]    mem_result,
   input  logic                 mem_is_load,
   input  logic [2:0]           mem_load_type,
   input  logic                 flush,
   input  logic                 data_ack,
   input  logic [DATA_W-1:0]    data_rdata,
   output logic                 stall_req,
   output logic                 gpr_we,
   output logic [REGADDR_W-1:0] gpr_waddr,
   output logic [DATA_W-1:0]    gpr_wdata
`ifdef WB_MISALIGN_EXC_EN
   ,
   output logic                 misalign_exc
`endif
);

   wb_state_t state_q, state_d;

   logic                 pend_we_p1;
   logic [REGADDR_W-1:0] pend_waddr_p1;
   logic [1:0]           pend_off_p1;
   load_type_t           pend_type_p1;

   logic                 complete;
   logic                 load_done;
   logic                 latch_pend;
   logic                 wr_we;
   logic [REGADDR_W-1:0] wr_waddr;
   logic [DATA_W-1:0]    wr_data;
   logic [1:0]           sel_off;
   load_type_t           sel_type;
   logic [DATA_W-1:0]    ext_data;
   logic                 mis_fault;

   // While waiting, the aligner must see the offset/type captured at issue.
   assign sel_off  = (state_q == WAIT) ? pend_off_p1 : mem_result[1:0];
   assign sel_type = (state_q == WAIT) ? pend_type_p1 : load_type_t'(mem_load_type);

   load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .data      (data_rdata),
      .offset    (sel_off),
      .load_type (sel_type),
      .ext       (ext_data)
   );

   always_comb begin
      state_d    = state_q;
      complete   = 1'b0;
      load_done  = 1'b0;
      latch_pend = 1'b0;
      wr_we      = mem_we;
      wr_waddr   = mem_waddr;
      wr_data    = mem_result;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_valid) begin
                  if (!mem_is_load) begin
                     complete = 1'b1;
                  end else if (data_ack) begin
                     complete  = 1'b1;
                     load_done = 1'b1;
                     wr_data   = ext_data;
                  end else begin
                     latch_pend = 1'b1;
                     state_d    = WAIT;
                  end
               end
            end
            WAIT: begin
               if (data_ack) begin
                  complete  = 1'b1;
                  load_done = 1'b1;
                  wr_we     = pend_we_p1;
                  wr_waddr  = pend_waddr_p1;
                  wr_data   = ext_data;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef WB_MISALIGN_EXC_EN
   assign mis_fault = load_done && is_misaligned(sel_type, sel_off);
`else
   assign mis_fault = 1'b0;
`endif

   // Stage boundary: registered write port, stall and pending-load latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         stall_req     <= 1'b0;
         gpr_we        <= 1'b0;
         gpr_waddr     <= '0;
         gpr_wdata     <= '0;
         pend_we_p1    <= 1'b0;
         pend_waddr_p1 <= '0;
         pend_off_p1   <= 2'b00;
         pend_type_p1  <= LB;
      end else begin
         state_q   <= state_d;
         stall_req <= (state_d == WAIT);
         gpr_we    <= complete && wr_we && (wr_waddr != '0) && !mis_fault;
         if (complete) begin
            gpr_waddr <= wr_waddr;
            gpr_wdata <= wr_data;
         end
         if (latch_pend) begin
            pend_we_p1    <= mem_we;
            pend_waddr_p1 <= mem_waddr;
            pend_off_p1   <= mem_result[1:0];
            pend_type_p1  <= load_type_t'(mem_load_type);
         end
      end
   end

`ifdef WB_MISALIGN_EXC_EN
   always_ff @(posedge clk) begin
      if (rst) misalign_exc <= 1'b0;
      else     misalign_exc <= mis_fault;
   end
`endif

endmodule
